// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit -- multi-cycle integer multiplier (mult / multu)
//
// A radix-2 shift-add multiplier for the execute stage. A start request is
// accepted only in IDLE and only while the unit is armed. The operands are
// reduced to magnitudes (signed mode) or taken raw (unsigned mode). WIDTH
// shift-add steps then run in BUSY. A single FIX cycle restores the sign and
// writes {hi,lo}. pve is low from the cycle after acceptance until the
// product is written, so the hazard unit can stall on it.
//
// The arming latch makes the unit edge-like on a level start: once a start
// is accepted, multstartE must be seen low at least once before another
// start can be taken. A start held through a stall therefore runs only once.
//
// Parameters
//   WIDTH       operand width; hi and lo are WIDTH bits each
//
// Ports
//   clk         sole clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   multstartE  start request (level) from the execute stage
//   signedE     1 = signed multiply, 0 = unsigned; sampled with the start
//   srcaE       multiplicand, sampled with the start
//   srcbE       multiplier, sampled with the start
//   pve         1 = idle and hi/lo valid, 0 = multiply in flight
//   hi          upper half of the last completed product
//   lo          lower half of the last completed product
// ---------------------------------------------------------------------------
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             multstartE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             pve,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic               armed;
   logic               neg;        // sign of the final product
   logic [WIDTH-1:0]   mcand;      // multiplicand magnitude
   logic [WIDTH-1:0]   mplier;     // multiplier magnitude, consumed LSB first
   logic [2*WIDTH-1:0] acc;        // partial product, shifts right each step
   logic [CNT_W-1:0]   cnt;        // index of the step being performed

   // -----------------------------------------------------------------------
   // Operand conditioning at acceptance time.
   // In signed mode a negative operand is replaced by its two's-complement
   // negation, read as an unsigned WIDTH-bit value. The most negative
   // operand negates to itself, and that bit pattern as an unsigned number
   // is exactly its magnitude. No extra bit is needed for it.
   // -----------------------------------------------------------------------
   logic               start_ok;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_in;

   // Shift-add datapath for one BUSY step and the sign fix-up for FIX.
   logic [WIDTH:0]     step_sum;   // upper half plus addend, with carry
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] product;

   // NOTE: every signal assigned in an always_comb gets a value on every path
   // (defaults first), so no latch can be inferred.
   always_comb begin
      start_ok = 1'b0;
      mag_a    = srcaE;
      mag_b    = srcbE;
      neg_in   = 1'b0;

      start_ok = (state == IDLE) && multstartE && armed;

      if (signedE) begin
         mag_a  = srcaE[WIDTH-1] ? -srcaE : srcaE;
         mag_b  = srcbE[WIDTH-1] ? -srcbE : srcbE;
         neg_in = srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
      end
   end

   // One radix-2 step. The current multiplier bit selects whether the
   // multiplicand is added into the upper half. The WIDTH+1 bit sum and the
   // lower half then shift right by one. After WIDTH steps the product bits
   // have walked down into their final positions, and acc holds the exact
   // 2*WIDTH magnitude product.
   always_comb begin
      step_sum = '0;
      acc_step = '0;
      product  = '0;

      step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      acc_step = {step_sum, acc[WIDTH-1:1]};
      product  = neg ? -acc : acc;
   end

   // -----------------------------------------------------------------------
   // Control FSM and all state.
   // pve, hi and lo are registered here, so the outputs are glitch-free and
   // reset asynchronously with the rest of the unit. A reset mid-operation
   // simply drops the in-flight work. hi/lo are written only on the
   // FIX -> IDLE edge, so an aborted multiply never leaves a partial result.
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values that existed before this clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         armed  <= 1'b1;
         neg    <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         pve    <= 1'b1;
         hi     <= '0;
         lo     <= '0;
      end else begin
         // Re-arm whenever the start request is seen low, in any state.
         // Acceptance needs multstartE=1, so it never competes with this.
         if (!multstartE) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  mcand  <= mag_a;
                  mplier <= mag_b;
                  neg    <= neg_in;
                  acc    <= '0;
                  cnt    <= '0;
                  armed  <= 1'b0;
                  pve    <= 1'b0;
                  state  <= BUSY;
               end
            end

            BUSY: begin
               acc    <= acc_step;
               mplier <= mplier >> 1;
               if (cnt == CNT_LAST) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            FIX: begin
               hi    <= product[2*WIDTH-1:WIDTH];
               lo    <= product[WIDTH-1:0];
               pve   <= 1'b1;
               state <= IDLE;
            end

            default: begin
               pve   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit -- self-checking bench for mult_unit (WIDTH = 32)
//
// Expected products come from plain 64-bit arithmetic on the operands as
// driven at acceptance. The expected busy window is WIDTH+1 cycles.
// Outputs are sampled on the falling edge. Inputs change only on the falling
// edge or just after the rising edge.
// ---------------------------------------------------------------------------
module tb_mult_unit;

   localparam int W        = 32;
   localparam int BUSY_LEN = W + 1;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         multstartE;
   logic         signedE;
   logic [W-1:0] srcaE;
   logic [W-1:0] srcbE;
   logic         pve;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mult_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .multstartE (multstartE),
      .signedE    (signedE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .pve        (pve),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Reference product: exact 64-bit result of the architectural operation.
   function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint     sp;
      logic [63:0] ua;
      logic [63:0] ub;
      if (s) begin
         sp = longint'($signed(a)) * longint'($signed(b));
         return sp;
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   // Present a start on a falling edge, let one rising edge accept it, then
   // drop the request.
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      multstartE = 1'b1;
      signedE    = s;
      srcaE      = a;
      srcbE      = b;
      @(posedge clk);
      #1 multstartE = 1'b0;
   endtask

   // Count falling edges with pve low (bounded). Track whether hi/lo held
   // the previous product. Optionally scramble the operands every cycle, or
   // raise the next start request during the last busy cycle.
   task automatic wait_done(input bit scramble, input bit b2b, input logic s2,
                            input logic [31:0] a2, input logic [31:0] b2,
                            input logic [63:0] prev, output int low, output bit held);
      low  = 0;
      held = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pve) break;
         low++;
         if ({hi, lo} !== prev) held = 1'b0;
         if (scramble) begin
            srcaE   = $urandom;
            srcbE   = $urandom;
            signedE = 1'($urandom_range(0, 1));
         end
         if (b2b && low == BUSY_LEN) begin
            multstartE = 1'b1;
            signedE    = s2;
            srcaE      = a2;
            srcbE      = b2;
         end
      end
   endtask

   task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, input string tag);
      logic [63:0] prev;
      logic [63:0] exp;
      int          low;
      bit          held;
      prev = {hi, lo};
      exp  = ref_prod(s, a, b);
      start_op(s, a, b);
      wait_done(scramble, 1'b0, 1'b0, 32'h0, 32'h0, prev, low, held);
      check({tag, "_pve_low"}, 64'(low), 64'(BUSY_LEN));
      check({tag, "_hold"},    64'(held), 64'd1);
      check({tag, "_hi"},      64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"},      64'(lo), 64'(exp[31:0]));
   endtask

   logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

   initial begin
      logic [63:0] prev;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
      int          low;
      int          lows;
      int          windows;
      bit          held;
      logic        prev_pve;
      logic        rs;
      logic [31:0] ra;
      logic [31:0] rb;

      reset_n    = 1'b0;
      multstartE = 1'b0;
      signedE    = 1'b0;
      srcaE      = '0;
      srcbE      = '0;
      #12;
      check("rst_pve", 64'(pve), 64'd1);
      check("rst_hi",  64'(hi),  64'd0);
      check("rst_lo",  64'(lo),  64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed products, including the most negative operand.
      run_mult(1'b0, 32'd7,          32'd6,          1'b0, "u7x6");
      run_mult(1'b1, 32'hFFFF_FFFD,  32'h0000_0005,  1'b0, "s_m3x5");
      run_mult(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, "u_max_sq");
      run_mult(1'b1, 32'h8000_0000,  32'h8000_0000,  1'b0, "s_min_sq");
      run_mult(1'b1, 32'h8000_0000,  32'h0000_0001,  1'b0, "s_min_x1");

      // Back-to-back: the next start is raised during FIX and is taken on
      // the first IDLE cycle, so pve is high for exactly one cycle.
      exp_a = ref_prod(1'b1, 32'hFFFF_FF00, 32'd300);
      exp_b = ref_prod(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      prev  = {hi, lo};
      start_op(1'b1, 32'hFFFF_FF00, 32'd300);
      wait_done(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, prev, low, held);
      check("b2b_first_pve_low", 64'(low), 64'(BUSY_LEN));
      check("b2b_first_prod",    {hi, lo}, exp_a);
      @(posedge clk);
      #1 multstartE = 1'b0;
      wait_done(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_a, low, held);
      check("b2b_second_pve_low", 64'(low), 64'(BUSY_LEN));
      check("b2b_second_hold",    64'(held), 64'd1);
      check("b2b_second_prod",    {hi, lo}, exp_b);

      // Start held high for 40 cycles: one busy window only.
      prev  = {hi, lo};
      exp_a = ref_prod(1'b0, 32'd1000, 32'd2000);
      @(negedge clk);
      multstartE = 1'b1;
      signedE    = 1'b0;
      srcaE      = 32'd1000;
      srcbE      = 32'd2000;
      windows    = 0;
      lows       = 0;
      held       = 1'b1;
      prev_pve   = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (prev_pve && !pve) windows++;
         if (!pve) begin
            lows++;
            if ({hi, lo} !== prev) held = 1'b0;
         end
         prev_pve = pve;
      end
      check("held_windows", 64'(windows), 64'd1);
      check("held_lows",    64'(lows),    64'(BUSY_LEN));
      check("held_hold",    64'(held),    64'd1);
      check("held_prod",    {hi, lo},     exp_a);
      multstartE = 1'b0;
      run_mult(1'b1, 32'hFFFF_FFF9, 32'd9, 1'b0, "held_rearm");

      // Reset in the middle of BUSY after a known product of 42.
      run_mult(1'b0, 32'd7, 32'd6, 1'b0, "pre_rst");
      start_op(1'b0, 32'd1234, 32'd5678);
      repeat (10) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_pve", 64'(pve), 64'd1);
      check("midrst_hi",  64'(hi),  64'd0);
      check("midrst_lo",  64'(lo),  64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_mult(1'b1, 32'hFFFF_FC00, 32'h0001_0000, 1'b0, "post_rst");

      // Operands scrambled every busy cycle must not affect the result.
      for (int i = 0; i < 4; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         run_mult(rs, ra, rb, 1'b1, "scramble");
      end

      // Random operands, biased toward the corner values.
      for (int i = 0; i < 20; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         run_mult(rs, ra, rb, 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
